// File: rtl/bus_arbiter_3_to_1_pkg.sv
// Shared constants for the 3-to-1 round-robin bus arbiter:
// FSM state codes, selector codes and port indices.
package bus_arbiter_3_to_1_pkg;

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUSY    = 2'd1;
  localparam logic [1:0] S_RELEASE = 2'd2;

  localparam logic [1:0] SEL_IDLE  = 2'b11;
  localparam logic [1:0] PORT0     = 2'd0;
  localparam logic [1:0] PORT1     = 2'd1;
  localparam logic [1:0] PORT2     = 2'd2;

  // The idle selector code maps to no grant, which keeps Grant_o one-hot-or-zero.
  function automatic logic [2:0] onehot3(input logic [1:0] idx);
    case (idx)
      PORT0:   return 3'b001;
      PORT1:   return 3'b010;
      PORT2:   return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

endpackage

// File: rtl/bus_arbiter_3_to_1_if.sv
// Requester/resource-side bundle of the arbiter: requests and completion in,
// grant, mux selector and status out.
interface bus_arbiter_3_to_1_if;

  logic [2:0] Req_i;
  logic       Done_i;
  logic [2:0] Grant_o;
  logic [1:0] Selector_o;
  logic       Busy_o;
  logic       Timeout_o;

  modport slave (
    input  Req_i, Done_i,
    output Grant_o, Selector_o, Busy_o, Timeout_o
  );

  modport master (
    output Req_i, Done_i,
    input  Grant_o, Selector_o, Busy_o, Timeout_o
  );

endinterface

// File: rtl/bus_arbiter_3_to_1_rr_pick_3.sv
// Combinational round-robin picker: searches lastPtr+1, +2, +3 (mod 3)
// and returns the first requesting port.
module rr_pick_3
  import bus_arbiter_3_to_1_pkg::*;
(
  input  logic [2:0] req_i,
  input  logic [1:0] lastPtr_i,
  output logic       valid_o,
  output logic [1:0] win_o
);

  always_comb begin
    valid_o = |req_i;
    win_o   = PORT0;
    case (lastPtr_i)
      PORT0: begin
        if      (req_i[1]) win_o = PORT1;
        else if (req_i[2]) win_o = PORT2;
        else               win_o = PORT0;
      end
      PORT1: begin
        if      (req_i[2]) win_o = PORT2;
        else if (req_i[0]) win_o = PORT0;
        else               win_o = PORT1;
      end
      default: begin
        if      (req_i[0]) win_o = PORT0;
        else if (req_i[1]) win_o = PORT1;
        else               win_o = PORT2;
      end
    endcase
  end

endmodule

// File: rtl/bus_arbiter_3_to_1.sv
// Round-robin arbiter sharing one resource between three requesters, with
// registered one-hot grant, mux selector, busy status and hold timeout.
module bus_arbiter_3_to_1
  import bus_arbiter_3_to_1_pkg::*;
#(
  parameter int MAX_HOLD = 16,
  parameter int CNT_W    = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  bus_arbiter_3_to_1_if.slave    bus
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  logic [1:0]       state_q,   state_d;
  logic [2:0]       grant_q,   grant_d;
  logic [1:0]       sel_q,     sel_d;
  logic             busy_q,    busy_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] holdCnt_q, holdCnt_d;
  logic [1:0]       lastPtr_q, lastPtr_d;
  logic             releaseGrant;
  logic             pickValid;
  logic [1:0]       pickWin;

  rr_pick_3 uPick (
    .req_i     (bus.Req_i),
    .lastPtr_i (lastPtr_q),
    .valid_o   (pickValid),
    .win_o     (pickWin)
  );

  // Owner withdrawal is detected through the grant mask, so no index decode is needed.
  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    sel_d        = sel_q;
    busy_d       = busy_q;
    timeout_d    = 1'b0;
    holdCnt_d    = holdCnt_q;
    lastPtr_d    = lastPtr_q;
    releaseGrant = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pickValid) begin
          state_d   = S_BUSY;
          grant_d   = onehot3(pickWin);
          sel_d     = pickWin;
          busy_d    = 1'b1;
          holdCnt_d = '0;
          lastPtr_d = pickWin;
        end
      end
      S_BUSY: begin
        if (bus.Done_i) begin
          releaseGrant = 1'b1;
        end else if (~|(grant_q & bus.Req_i)) begin
          releaseGrant = 1'b1;
        end else if (holdCnt_q == HOLD_LAST) begin
          releaseGrant = 1'b1;
          timeout_d    = 1'b1;
        end else if (holdCnt_q < HOLD_LAST) begin
          holdCnt_d = holdCnt_q + CNT_W'(1);
        end
      end
      S_RELEASE: state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
    if (releaseGrant) begin
      state_d   = S_RELEASE;
      grant_d   = 3'b000;
      sel_d     = SEL_IDLE;
      busy_d    = 1'b0;
      holdCnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      grant_q   <= 3'b000;
      sel_q     <= SEL_IDLE;
      busy_q    <= 1'b0;
      timeout_q <= 1'b0;
      holdCnt_q <= '0;
      lastPtr_q <= PORT2;
    end else begin
      state_q   <= state_d;
      grant_q   <= grant_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      timeout_q <= timeout_d;
      holdCnt_q <= holdCnt_d;
      lastPtr_q <= lastPtr_d;
    end
  end

  assign bus.Grant_o    = grant_q;
  assign bus.Selector_o = sel_q;
  assign bus.Busy_o     = busy_q;
  assign bus.Timeout_o  = timeout_q;

endmodule

// File: tb/tb_bus_arbiter_3_to_1.sv
// Scoreboard bench for bus_arbiter_3_to_1: a cycle-level reference model
// queues expected outputs, a monitor pops and compares after each edge.
module tb_bus_arbiter_3_to_1;

  localparam int MAX_HOLD = 16;
  localparam int CNT_W    = 5;

  typedef struct packed {
    logic [2:0] grant;
    logic [1:0] sel;
    logic       busy;
    logic       timeout;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  bus_arbiter_3_to_1_if bus ();

  bus_arbiter_3_to_1 #(
    .MAX_HOLD (MAX_HOLD),
    .CNT_W    (CNT_W)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t expQ[$];
  exp_t monExp;
  int   vectorCount = 0;
  int   missCount   = 0;
  int   pushCount   = 0;
  int   popCount    = 0;

  // Reference model: phase 0 = free, 1 = owned, 2 = mandatory gap cycle.
  int   mPhase;
  int   mOwner;
  int   mHeld;
  int   mLast;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    vectorCount++;
    if (act !== req) begin
      missCount++;
      $display("[TB] FAIL %s at %0t: actual=%0h required=%0h", name, $time, act, req);
    end
  endtask

  function automatic void modelReset();
    mPhase = 0;
    mOwner = -1;
    mHeld  = 0;
    mLast  = 2;
  endfunction

  task automatic modelStep(input logic [2:0] req, input logic done, output exp_t e);
    logic timeoutOut;
    logic doRelease;
    timeoutOut = 1'b0;
    doRelease  = 1'b0;
    if (mPhase == 2) begin
      mPhase = 0;
    end else if (mPhase == 0) begin
      for (int k = 1; k <= 3; k++) begin
        if (mPhase == 0 && req[(mLast + k) % 3]) begin
          mOwner = (mLast + k) % 3;
          mLast  = mOwner;
          mHeld  = 0;
          mPhase = 1;
        end
      end
    end else begin
      if (done)                      doRelease = 1'b1;
      else if (!req[mOwner])         doRelease = 1'b1;
      else if (mHeld == MAX_HOLD - 1) begin
        doRelease  = 1'b1;
        timeoutOut = 1'b1;
      end else mHeld++;
      if (doRelease) begin
        mOwner = -1;
        mPhase = 2;
      end
    end
    e.grant   = (mOwner < 0) ? 3'b000 : 3'(1 << mOwner);
    e.sel     = (mOwner < 0) ? 2'b11  : 2'(mOwner);
    e.busy    = (mOwner >= 0);
    e.timeout = timeoutOut;
  endtask

  task automatic applyStimulus(input logic [2:0] req, input logic done);
    exp_t e;
    @(negedge clk);
    bus.Req_i  = req;
    bus.Done_i = done;
    modelStep(req, done, e);
    expQ.push_back(e);
    pushCount++;
  endtask

  task automatic applyIdle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(3'b000, 1'b0);
  endtask

  task automatic resetMid();
    @(posedge clk);
    #2 reset = 1'b1;
    #1;
    checkOutput("asyncRstGrant",   32'(bus.Grant_o),    32'h0);
    checkOutput("asyncRstSel",     32'(bus.Selector_o), 32'h3);
    checkOutput("asyncRstBusy",    32'(bus.Busy_o),     32'h0);
    checkOutput("asyncRstTimeout", 32'(bus.Timeout_o),  32'h0);
    #1 reset = 1'b0;
    modelReset();
  endtask

  function automatic logic [1:0] selFromGrant(input logic [2:0] g);
    case (g)
      3'b001:  return 2'd0;
      3'b010:  return 2'd1;
      3'b100:  return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  // Monitor: scoreboard compare plus structural invariants, every cycle.
  always begin
    @(posedge clk);
    #1;
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      popCount++;
      checkOutput("grant",    32'(bus.Grant_o),    32'(monExp.grant));
      checkOutput("selector", 32'(bus.Selector_o), 32'(monExp.sel));
      checkOutput("busy",     32'(bus.Busy_o),     32'(monExp.busy));
      checkOutput("timeout",  32'(bus.Timeout_o),  32'(monExp.timeout));
    end
    checkOutput("grantOnehot0", 32'($onehot0(bus.Grant_o)), 32'h1);
    checkOutput("selMatchesGrant", 32'(bus.Selector_o), 32'(selFromGrant(bus.Grant_o)));
  end

  initial begin
    logic [2:0] reqLevel;
    reset      = 1'b1;
    bus.Req_i  = 3'b000;
    bus.Done_i = 1'b0;
    modelReset();
    #3;
    checkOutput("rstGrant",   32'(bus.Grant_o),    32'h0);
    checkOutput("rstSel",     32'(bus.Selector_o), 32'h3);
    checkOutput("rstBusy",    32'(bus.Busy_o),     32'h0);
    checkOutput("rstTimeout", 32'(bus.Timeout_o),  32'h0);
    @(posedge clk);
    #4 reset = 1'b0;

    // Reset while port 1 owns the bus, then all ports request: port 0 first.
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0);
    applyStimulus(3'b010, 1'b0);
    resetMid();
    for (int i = 0; i < 6; i++) applyStimulus(3'b111, i == 2);
    applyIdle(3);

    // Single request with completion.
    for (int i = 0; i < 4; i++) applyStimulus(3'b010, i == 3);
    applyIdle(3);

    // Round robin with all ports requesting.
    for (int i = 0; i < 24; i++) applyStimulus(3'b111, (i % 6) == 4);
    applyIdle(3);

    // Timeout with no completion, then completion on the last allowed cycle.
    applyStimulus(3'b100, 1'b0);
    for (int j = 0; j < MAX_HOLD; j++) applyStimulus(3'b100, 1'b0);
    applyIdle(3);
    applyStimulus(3'b100, 1'b0);
    for (int j = 0; j < MAX_HOLD; j++) applyStimulus(3'b100, j == MAX_HOLD - 1);
    applyIdle(3);

    // Owner 0 withdraws while port 2 waits.
    applyStimulus(3'b001, 1'b0);
    applyStimulus(3'b101, 1'b0);
    applyStimulus(3'b101, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(3'b100, i == 4);
    applyIdle(3);

    // Completion pulses outside BUSY.
    for (int i = 0; i < 4; i++) applyStimulus(3'b000, 1'b1);

    // Randomised level requests and completion pulses.
    reqLevel = 3'b000;
    for (int i = 0; i < 500; i++) begin
      for (int p = 0; p < 3; p++)
        if ($urandom_range(0, 7) == 0) reqLevel[p] = ~reqLevel[p];
      applyStimulus(reqLevel, $urandom_range(0, 5) == 0);
    end
    applyIdle(3);

    @(posedge clk);
    #3;
    checkOutput("queueDrained", 32'(popCount), 32'(pushCount));
    $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
    $finish;
  end

endmodule
